wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the pipeline write with queued long-latency results
// onto one register-file write port and tracks busy destinations in a scoreboard.
module wb_arbiter #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int ADDR_SIZE   = 32,
    parameter int QDEPTH      = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   p_valid,
    input  logic [RFIDX_WIDTH-1:0] p_rd,
    input  logic [XLEN-1:0]        p_data,
    input  logic [ADDR_SIZE-1:0]   p_pc,
    input  logic                   l_valid,
    output logic                   l_ready,
    input  logic [RFIDX_WIDTH-1:0] l_rd,
    input  logic [XLEN-1:0]        l_data,
    input  logic [ADDR_SIZE-1:0]   l_pc,
    input  logic                   iss_valid,
    input  logic [RFIDX_WIDTH-1:0] iss_rd,
    input  logic [RFIDX_WIDTH-1:0] q_ra1,
    input  logic [RFIDX_WIDTH-1:0] q_ra2,
    output logic                   q_busy1,
    output logic                   q_busy2,
    output logic                   we3,
    output logic [RFIDX_WIDTH-1:0] wa3,
    output logic [XLEN-1:0]        wd3,
    output logic [ADDR_SIZE-1:0]   pc,
    output logic                   waw_err
);

    localparam int AW    = $clog2(QDEPTH);
    localparam int CW    = AW + 1;
    localparam int NREGS = 1 << RFIDX_WIDTH;

    logic [RFIDX_WIDTH-1:0] q_rd_q   [QDEPTH];
    logic [RFIDX_WIDTH-1:0] q_rd_d   [QDEPTH];
    logic [XLEN-1:0]        q_data_q [QDEPTH];
    logic [XLEN-1:0]        q_data_d [QDEPTH];
    logic [ADDR_SIZE-1:0]   q_pc_q   [QDEPTH];
    logic [ADDR_SIZE-1:0]   q_pc_d   [QDEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             waw_err_q, waw_err_d;

    logic             head_vld;
    logic             sel_q;
    logic             push;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    logic [RFIDX_WIDTH-1:0] head_rd;
    logic [XLEN-1:0]        head_data;
    logic [ADDR_SIZE-1:0]   head_pc;

    assign head_rd   = q_rd_q[rd_ptr_q];
    assign head_data = q_data_q[rd_ptr_q];
    assign head_pc   = q_pc_q[rd_ptr_q];

    // Ready looks only at occupancy, never at a same-cycle pop.
    assign l_ready  = (count_q != CW'(QDEPTH));
    assign head_vld = rstn && (count_q != '0);
    assign sel_q    = head_vld && !p_valid;
    assign push     = l_valid && l_ready;

    always_comb begin
        wa3 = head_rd;
        wd3 = head_data;
        pc  = head_pc;
        we3 = sel_q && (head_rd != '0);
        if (p_valid) begin
            wa3 = p_rd;
            wd3 = p_data;
            pc  = p_pc;
            we3 = rstn && (p_rd != '0);
        end
    end

    always_comb begin
        q_rd_d   = q_rd_q;
        q_data_d = q_data_q;
        q_pc_d   = q_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            q_rd_d[wr_ptr_q]   = l_rd;
            q_data_d[wr_ptr_q] = l_data;
            q_pc_d[wr_ptr_q]   = l_pc;
            wr_ptr_d           = wr_ptr_q + AW'(1);
        end
        if (sel_q) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(sel_q);
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && (iss_rd != '0)) begin
            set_vec[iss_rd] = 1'b1;
        end
        if (sel_q && (head_rd != '0)) begin
            clr_vec[head_rd] = 1'b1;
        end
        // Set is applied after clear so a re-issue wins over retirement.
        busy_d = ((busy_q & ~clr_vec) | set_vec) & ~NREGS'(1);
        waw_err_d = waw_err_q
                  | (p_valid && (p_rd != '0) && busy_q[p_rd]);
    end

    // A register retiring this cycle reads as free.
    assign q_busy1 = busy_q[q_ra1] & ~clr_vec[q_ra1];
    assign q_busy2 = busy_q[q_ra2] & ~clr_vec[q_ra2];
    assign waw_err = waw_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_rd_q[i]   <= '0;
                q_data_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            waw_err_q <= 1'b0;
        end else begin
            q_rd_q    <= q_rd_d;
            q_data_q  <= q_data_d;
            q_pc_q    <= q_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            waw_err_q <= waw_err_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed vectors for priority,
// queueing, scoreboard and reset behaviour.
module tb_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic [31:0] p_pc;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_rd;
    logic [31:0] l_data;
    logic [31:0] l_pc;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_ra1;
    logic [4:0]  q_ra2;
    logic        q_busy1;
    logic        q_busy2;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pc;
    logic        waw_err;

    int n_cmp;
    int n_err;

    wb_arbiter #(
        .XLEN(32),
        .RFIDX_WIDTH(5),
        .ADDR_SIZE(32),
        .QDEPTH(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .p_valid(p_valid),
        .p_rd(p_rd),
        .p_data(p_data),
        .p_pc(p_pc),
        .l_valid(l_valid),
        .l_ready(l_ready),
        .l_rd(l_rd),
        .l_data(l_data),
        .l_pc(l_pc),
        .iss_valid(iss_valid),
        .iss_rd(iss_rd),
        .q_ra1(q_ra1),
        .q_ra2(q_ra2),
        .q_busy1(q_busy1),
        .q_busy2(q_busy2),
        .we3(we3),
        .wa3(wa3),
        .wd3(wd3),
        .pc(pc),
        .waw_err(waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid   = 1'b0;
        p_rd      = '0;
        p_data    = '0;
        p_pc      = '0;
        l_valid   = 1'b0;
        l_rd      = '0;
        l_data    = '0;
        l_pc      = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        q_ra1 = '0;
        q_ra2 = '0;
        idle();
        #2;
        check("rst_lready", 64'(l_ready), 64'd1);
        check("rst_we3", 64'(we3), 64'd0);
        check("rst_waw", 64'(waw_err), 64'd0);
        check("rst_busy", 64'(q_busy1), 64'd0);
        p_valid = 1'b1;
        p_rd    = 5'd2;
        p_data  = 32'hDEAD;
        #1;
        check("rst_pwe", 64'(we3), 64'd0);
        check("rst_pwa", 64'(wa3), 64'd2);
        check("rst_pwd", 64'(wd3), 64'hDEAD);
        idle();
        tick();
        tick();
        #1 rstn = 1'b1;
        tick();

        // issue rd5, long result later, write one cycle after accept
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        tick();
        idle();
        q_ra1   = 5'd5;
        l_valid = 1'b1;
        l_rd    = 5'd5;
        l_data  = 32'h1234;
        l_pc    = 32'h100;
        #1;
        check("t29_busy", 64'(q_busy1), 64'd1);
        check("t29_nobyp", 64'(we3), 64'd0);
        check("t29_rdy", 64'(l_ready), 64'd1);
        tick();
        idle();
        #1;
        check("t29_we", 64'(we3), 64'd1);
        check("t29_wa", 64'(wa3), 64'd5);
        check("t29_wd", 64'(wd3), 64'h1234);
        check("t29_pc", 64'(pc), 64'h100);
        check("t29_clrvis", 64'(q_busy1), 64'd0);
        tick();
        check("t29_busy0", 64'(q_busy1), 64'd0);
        check("t29_idle", 64'(we3), 64'd0);

        // pipeline holds port, queue fills and refuses
        p_valid = 1'b1;
        p_rd    = 5'd1;
        p_data  = 32'hAA;
        l_valid = 1'b1;
        l_rd    = 5'd3;
        l_data  = 32'h33;
        #1;
        check("t30_c1_wa", 64'(wa3), 64'd1);
        check("t30_c1_wd", 64'(wd3), 64'hAA);
        check("t30_c1_rdy", 64'(l_ready), 64'd1);
        tick();
        l_rd   = 5'd4;
        l_data = 32'h44;
        #1;
        check("t30_c2_rdy", 64'(l_ready), 64'd1);
        tick();
        l_rd   = 5'd6;
        l_data = 32'h66;
        #1;
        check("t30_c3_rdy", 64'(l_ready), 64'd0);
        check("t30_c3_wa", 64'(wa3), 64'd1);
        tick();
        #1;
        check("t30_c4_rdy", 64'(l_ready), 64'd0);
        check("t30_c4_we", 64'(we3), 64'd1);
        tick();
        p_valid = 1'b0;
        #1;
        check("t30_x3_we", 64'(we3), 64'd1);
        check("t30_x3_wa", 64'(wa3), 64'd3);
        check("t30_x3_wd", 64'(wd3), 64'h33);
        check("t30_fullpop", 64'(l_ready), 64'd0);
        tick();
        idle();
        #1;
        check("t30_x4_we", 64'(we3), 64'd1);
        check("t30_x4_wa", 64'(wa3), 64'd4);
        check("t30_x4_wd", 64'(wd3), 64'h44);
        check("t30_x4_rdy", 64'(l_ready), 64'd1);
        tick();
        check("t30_empty", 64'(we3), 64'd0);

        // rd0 result is consumed without a write
        l_valid = 1'b1;
        l_rd    = 5'd0;
        l_data  = 32'hFFFF;
        tick();
        l_rd   = 5'd8;
        l_data = 32'h88;
        #1;
        check("t31_we0", 64'(we3), 64'd0);
        check("t31_rdy", 64'(l_ready), 64'd1);
        tick();
        idle();
        #1;
        check("t31_nx_we", 64'(we3), 64'd1);
        check("t31_nx_wa", 64'(wa3), 64'd8);
        check("t31_nx_wd", 64'(wd3), 64'h88);
        tick();
        check("t31_empty", 64'(we3), 64'd0);
        check("t31_rdy2", 64'(l_ready), 64'd1);

        // re-issue of rd7 in the retiring cycle keeps it busy
        q_ra1     = 5'd7;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        idle();
        l_valid = 1'b1;
        l_rd    = 5'd7;
        l_data  = 32'h77;
        tick();
        idle();
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        #1;
        check("t32_wa", 64'(wa3), 64'd7);
        check("t32_we", 64'(we3), 64'd1);
        check("t32_clrvis", 64'(q_busy1), 64'd0);
        tick();
        idle();
        check("t32_kept", 64'(q_busy1), 64'd1);
        l_valid = 1'b1;
        l_rd    = 5'd7;
        l_data  = 32'h78;
        tick();
        idle();
        tick();
        check("t32_freed", 64'(q_busy1), 64'd0);

        // pipeline write to a busy register
        q_ra2     = 5'd9;
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        idle();
        p_valid = 1'b1;
        p_rd    = 5'd9;
        p_data  = 32'h99;
        #1;
        check("t33_we", 64'(we3), 64'd1);
        check("t33_wa", 64'(wa3), 64'd9);
        check("t33_wd", 64'(wd3), 64'h99);
        check("t33_waw0", 64'(waw_err), 64'd0);
        tick();
        idle();
        check("t33_waw1", 64'(waw_err), 64'd1);
        check("t33_still", 64'(q_busy2), 64'd1);
        tick();
        check("t33_sticky", 64'(waw_err), 64'd1);

        // mid-cycle reset with two queued entries
        q_ra1     = 5'd10;
        q_ra2     = 5'd11;
        p_valid   = 1'b1;
        p_rd      = 5'd1;
        iss_valid = 1'b1;
        iss_rd    = 5'd10;
        l_valid   = 1'b1;
        l_rd      = 5'd10;
        l_data    = 32'hA0;
        tick();
        iss_rd = 5'd11;
        l_rd   = 5'd11;
        l_data = 32'hB0;
        tick();
        iss_valid = 1'b0;
        l_valid   = 1'b0;
        #1;
        check("t34_full", 64'(l_ready), 64'd0);
        check("t34_b10", 64'(q_busy1), 64'd1);
        check("t34_b11", 64'(q_busy2), 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("t34_rdy", 64'(l_ready), 64'd1);
        check("t34_qb1", 64'(q_busy1), 64'd0);
        check("t34_qb2", 64'(q_busy2), 64'd0);
        check("t34_waw", 64'(waw_err), 64'd0);
        check("t34_we", 64'(we3), 64'd0);
        idle();
        tick();
        #2 rstn = 1'b1;
        tick();
        check("t34_post1", 64'(we3), 64'd0);
        tick();
        check("t34_post2", 64'(we3), 64'd0);
        check("t34_prdy", 64'(l_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
